// File: rtl/nb_pkg.sv
// Shared nb-core definitions: datapath widths and the memory-owner encoding
// used by the instruction/data memory arbiter.
package nb_pkg;

    localparam int XLEN = 32;
    localparam int BE_W = 4;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_D    = 2'd2
    } owner_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the fetch port, load/store port and unified-memory port around
// mem_arbiter. The slave view belongs to the arbiter, the master view to its environment.
interface mem_arbiter_if
    import nb_pkg::*;
#(
    parameter int AW = 32
);
    logic            if_req;
    logic [AW-1:0]   if_addr;
    logic            if_gnt;
    logic            if_rvalid;
    logic [XLEN-1:0] if_rdata;

    logic            d_req;
    logic            d_we;
    logic [BE_W-1:0] d_be;
    logic [AW-1:0]   d_addr;
    logic [XLEN-1:0] d_wdata;
    logic            d_gnt;
    logic            d_rvalid;
    logic [XLEN-1:0] d_rdata;

    logic            mem_en;
    logic            mem_we;
    logic [BE_W-1:0] mem_be;
    logic [AW-1:0]   mem_addr;
    logic [XLEN-1:0] mem_wdata;
    logic [XLEN-1:0] mem_rdata;

    modport slave (
        input  if_req, if_addr,
        output if_gnt, if_rvalid, if_rdata,
        input  d_req, d_we, d_be, d_addr, d_wdata,
        output d_gnt, d_rvalid, d_rdata,
        output mem_en, mem_we, mem_be, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output if_req, if_addr,
        input  if_gnt, if_rvalid, if_rdata,
        output d_req, d_we, d_be, d_addr, d_wdata,
        input  d_gnt, d_rvalid, d_rdata,
        input  mem_en, mem_we, mem_be, mem_addr, mem_wdata,
        output mem_rdata
    );

endinterface

// File: rtl/mem_arb_starve_cnt.sv
// Saturating count of consecutive cycles in which a pending fetch was denied;
// at_limit hands priority to fetch on the next contended cycle.
module mem_arb_starve_cnt #(
    parameter int STARVE_LIMIT = 4,
    parameter int CW           = $clog2(STARVE_LIMIT + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          if_req,
    input  logic          if_gnt,
    output logic [CW-1:0] starve_q,
    output logic          at_limit
);

    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_q <= '0;
        end else if (!if_req || if_gnt) begin
            starve_q <= '0;
        end else if (starve_q != LIMIT) begin
            starve_q <= starve_q + 1'b1;
        end
    end

    assign at_limit = (starve_q == LIMIT);

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port, one-cycle-latency memory between fetch and load/store.
// Data wins by default; fetch wins under contention once it has starved STARVE_LIMIT cycles.
module mem_arbiter
    import nb_pkg::*;
#(
    parameter int AW           = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    mem_arbiter_if.slave  bus
);

    localparam int CW = $clog2(STARVE_LIMIT + 1);

    logic [CW-1:0] starve_q;
    logic          at_limit;
    logic          if_gnt;
    logic          d_gnt;
    logic [AW-1:0] addr_sel;
    owner_e        owner_q;
    owner_e        owner_d;

    always_comb begin
        if_gnt = 1'b0;
        d_gnt  = 1'b0;
        if (bus.d_req && !(bus.if_req && at_limit)) begin
            d_gnt = 1'b1;
        end else if (bus.if_req) begin
            if_gnt = 1'b1;
        end
    end

    always_comb begin
        addr_sel      = '0;
        bus.mem_we    = 1'b0;
        bus.mem_be    = '0;
        bus.mem_wdata = '0;
        if (d_gnt) begin
            addr_sel      = bus.d_addr;
            bus.mem_we    = bus.d_we;
            bus.mem_be    = bus.d_be;
            bus.mem_wdata = bus.d_wdata;
        end else if (if_gnt) begin
            addr_sel   = bus.if_addr;
            bus.mem_be = '1;
        end
    end

    assign bus.mem_en   = if_gnt | d_gnt;
    assign bus.mem_addr = addr_sel;
    assign bus.if_gnt   = if_gnt;
    assign bus.d_gnt    = d_gnt;

    // Owner of the access whose read data returns next cycle; no holding state.
    always_comb begin
        owner_d = OWN_NONE;
        if (if_gnt) begin
            owner_d = OWN_IF;
        end else if (d_gnt) begin
            owner_d = OWN_D;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_q <= OWN_NONE;
        end else begin
            owner_q <= owner_d;
        end
    end

    assign bus.if_rvalid = (owner_q == OWN_IF);
    assign bus.d_rvalid  = (owner_q == OWN_D);
    assign bus.if_rdata  = bus.mem_rdata;
    assign bus.d_rdata   = bus.mem_rdata;

    mem_arb_starve_cnt #(
        .STARVE_LIMIT (STARVE_LIMIT),
        .CW           (CW)
    ) u_starve (
        .clk      (clk),
        .rst_n    (rst_n),
        .if_req   (bus.if_req),
        .if_gnt   (if_gnt),
        .starve_q (starve_q),
        .at_limit (at_limit)
    );

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: fetch, store/load, starvation, back-to-back,
// reset during an access, and a STARVE_LIMIT=1 instance for alternation.
module tb_mem_arbiter;
    import nb_pkg::*;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    mem_arbiter_if #(.AW(32)) bus ();
    mem_arbiter_if #(.AW(32)) bus1 ();

    mem_arbiter #(.AW(32), .STARVE_LIMIT(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    mem_arbiter #(.AW(32), .STARVE_LIMIT(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: byte-enabled writes, registered reads.
    logic [31:0] mem [0:255];
    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_we) begin
                for (int b = 0; b < 4; b++)
                    if (bus.mem_be[b]) mem[bus.mem_addr[9:2]][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
            end
            bus.mem_rdata <= mem[bus.mem_addr[9:2]];
        end
    end

    // Requesters must hold a request until it is granted.
    logic if_pend, d_pend;
    always @(posedge clk) begin
        if (rst_n && if_pend) assert (bus.if_req) else $error("fetch request withdrawn before grant");
        if (rst_n && d_pend)  assert (bus.d_req)  else $error("data request withdrawn before grant");
        if_pend <= rst_n && bus.if_req && !bus.if_gnt;
        d_pend  <= rst_n && bus.d_req && !bus.d_gnt;
    end

    localparam logic [31:0] W0 = 32'h02a00093;
    localparam logic [31:0] W1 = 32'h00500113;
    localparam logic [31:0] W2 = 32'h002081b3;

    task automatic idle_inputs();
        bus.if_req = 0; bus.if_addr = '0;
        bus.d_req = 0; bus.d_we = 0; bus.d_be = '0; bus.d_addr = '0; bus.d_wdata = '0;
    endtask

    task automatic test_reset();
        @(negedge clk); #1;
        checks++;
        if (bus.if_rvalid !== 1'b0 || bus.d_rvalid !== 1'b0) begin
            errors++; $display("FAIL reset_rvalid: got if=%b d=%b expected 0 0", bus.if_rvalid, bus.d_rvalid);
        end
        checks++;
        if ({bus.mem_en, bus.mem_we, bus.mem_be, bus.mem_addr, bus.mem_wdata} !== '0) begin
            errors++; $display("FAIL reset_idle_mem: got en=%b be=%h addr=%h expected all zero",
                               bus.mem_en, bus.mem_be, bus.mem_addr);
        end
        checks++;
        if (dut.starve_q !== 3'd0) begin
            errors++; $display("FAIL reset_starve: got %0d expected 0", dut.starve_q);
        end
        rst_n = 1;
    endtask

    task automatic test_fetch_only();
        @(negedge clk);
        bus.if_req = 1; bus.if_addr = 32'h0;
        #1;
        checks++;
        if ({bus.if_gnt, bus.d_gnt, bus.mem_en, bus.mem_we, bus.mem_be} !== {1'b1, 1'b0, 1'b1, 1'b0, 4'hF}
            || bus.mem_addr !== 32'h0) begin
            errors++; $display("FAIL fetch_grant: got gnt=%b dgnt=%b en=%b we=%b be=%h addr=%h expected 1 0 1 0 f 0",
                               bus.if_gnt, bus.d_gnt, bus.mem_en, bus.mem_we, bus.mem_be, bus.mem_addr);
        end
        @(negedge clk);
        bus.if_req = 0;
        #1;
        checks++;
        if (bus.if_rvalid !== 1'b1 || bus.if_rdata !== W0 || bus.d_rvalid !== 1'b0) begin
            errors++; $display("FAIL fetch_resp: got rvalid=%b rdata=%h drvalid=%b expected 1 %h 0",
                               bus.if_rvalid, bus.if_rdata, bus.d_rvalid, W0);
        end
        @(negedge clk); #1;
        checks++;
        if (bus.if_rvalid !== 1'b0 || bus.mem_en !== 1'b0) begin
            errors++; $display("FAIL fetch_after: got rvalid=%b en=%b expected 0 0", bus.if_rvalid, bus.mem_en);
        end
    endtask

    task automatic test_store_load();
        @(negedge clk);
        bus.d_req = 1; bus.d_we = 1; bus.d_be = 4'b0011; bus.d_addr = 32'h100; bus.d_wdata = 32'hDEADBEEF;
        #1;
        checks++;
        if ({bus.d_gnt, bus.mem_en, bus.mem_we, bus.mem_be} !== {1'b1, 1'b1, 1'b1, 4'b0011}
            || bus.mem_addr !== 32'h100 || bus.mem_wdata !== 32'hDEADBEEF) begin
            errors++; $display("FAIL store_drive: got gnt=%b we=%b be=%b addr=%h wdata=%h expected 1 1 0011 100 deadbeef",
                               bus.d_gnt, bus.mem_we, bus.mem_be, bus.mem_addr, bus.mem_wdata);
        end
        @(negedge clk);
        bus.d_we = 0; bus.d_be = 4'b0000; bus.d_wdata = '0;
        #1;
        checks++;
        if (bus.d_rvalid !== 1'b1 || bus.if_rvalid !== 1'b0) begin
            errors++; $display("FAIL store_ack: got drvalid=%b ifrvalid=%b expected 1 0", bus.d_rvalid, bus.if_rvalid);
        end
        checks++;
        if (bus.d_gnt !== 1'b1 || bus.mem_we !== 1'b0) begin
            errors++; $display("FAIL load_grant: got gnt=%b we=%b expected 1 0", bus.d_gnt, bus.mem_we);
        end
        @(negedge clk);
        bus.d_req = 0;
        #1;
        checks++;
        if (bus.d_rvalid !== 1'b1 || bus.d_rdata !== 32'h0000BEEF) begin
            errors++; $display("FAIL load_data: got rvalid=%b rdata=%h expected 1 0000beef", bus.d_rvalid, bus.d_rdata);
        end
    endtask

    task automatic test_starvation();
        logic exp_d;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            bus.if_req = (c <= 4); bus.if_addr = 32'h8;
            bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h100;
            #1;
            exp_d = (c != 4);
            checks++;
            if (bus.d_gnt !== exp_d || bus.if_gnt !== (c == 4)) begin
                errors++; $display("FAIL starve_gnt_c%0d: got d=%b if=%b expected d=%b if=%b",
                                   c, bus.d_gnt, bus.if_gnt, exp_d, (c == 4));
            end
            checks++;
            if (dut.starve_q !== ((c <= 4) ? 3'(c) : 3'd0)) begin
                errors++; $display("FAIL starve_cnt_c%0d: got %0d expected %0d",
                                   c, dut.starve_q, (c <= 4) ? c : 0);
            end
        end
        @(negedge clk);
        idle_inputs();
        #1;
        checks++;
        if (dut.starve_q !== 3'd0 || bus.d_rvalid !== 1'b1) begin
            errors++; $display("FAIL starve_end: got cnt=%0d drvalid=%b expected 0 1", dut.starve_q, bus.d_rvalid);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_w [3];
        exp_w[0] = W0; exp_w[1] = W1; exp_w[2] = W2;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i < 3) begin
                bus.if_req = 1; bus.if_addr = 32'(4 * i);
            end else begin
                bus.if_req = 0;
            end
            #1;
            if (i > 0) begin
                checks++;
                if (bus.if_rvalid !== 1'b1 || bus.if_rdata !== exp_w[i-1]) begin
                    errors++; $display("FAIL b2b_resp%0d: got rvalid=%b rdata=%h expected 1 %h",
                                       i - 1, bus.if_rvalid, bus.if_rdata, exp_w[i-1]);
                end
            end
            if (i < 3) begin
                checks++;
                if (bus.if_gnt !== 1'b1 || bus.mem_addr !== 32'(4 * i)) begin
                    errors++; $display("FAIL b2b_gnt%0d: got gnt=%b addr=%h expected 1 %h",
                                       i, bus.if_gnt, bus.mem_addr, 4 * i);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        bus.if_req = 1; bus.if_addr = 32'h0; bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h100;
        @(negedge clk);
        #1;
        checks++;
        if (bus.d_gnt !== 1'b1 || bus.d_rvalid !== 1'b1 || dut.starve_q !== 3'd1) begin
            errors++; $display("FAIL rstmid_pre: got gnt=%b rvalid=%b cnt=%0d expected 1 1 1",
                               bus.d_gnt, bus.d_rvalid, dut.starve_q);
        end
        rst_n = 0;
        idle_inputs();
        #1;
        checks++;
        if (bus.d_rvalid !== 1'b0 || dut.starve_q !== 3'd0) begin
            errors++; $display("FAIL rstmid_async: got rvalid=%b cnt=%0d expected 0 0", bus.d_rvalid, dut.starve_q);
        end
        @(negedge clk);
        rst_n = 1;
        #1;
        checks++;
        if (bus.d_rvalid !== 1'b0 || bus.mem_en !== 1'b0) begin
            errors++; $display("FAIL rstmid_release: got rvalid=%b en=%b expected 0 0", bus.d_rvalid, bus.mem_en);
        end
        @(negedge clk); #1;
        checks++;
        if (bus.d_rvalid !== 1'b0 || bus.if_rvalid !== 1'b0 || bus.mem_en !== 1'b0) begin
            errors++; $display("FAIL rstmid_idle: got drvalid=%b ifrvalid=%b en=%b expected 0 0 0",
                               bus.d_rvalid, bus.if_rvalid, bus.mem_en);
        end
    endtask

    task automatic test_limit_one();
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            bus1.if_req = 1; bus1.d_req = 1;
            #1;
            checks++;
            if (bus1.d_gnt !== (c % 2 == 0) || bus1.if_gnt !== (c % 2 == 1)) begin
                errors++; $display("FAIL lim1_c%0d: got d=%b if=%b expected d=%b if=%b",
                                   c, bus1.d_gnt, bus1.if_gnt, (c % 2 == 0), (c % 2 == 1));
            end
        end
        @(negedge clk);
        bus1.if_req = 0; bus1.d_req = 0;
    endtask

    initial begin
        errors = 0; checks = 0;
        rst_n = 0;
        for (int i = 0; i < 256; i++) mem[i] = '0;
        mem[0] = W0; mem[1] = W1; mem[2] = W2;
        bus.mem_rdata = '0;
        idle_inputs();
        bus1.if_req = 0; bus1.if_addr = 32'h40; bus1.d_req = 0; bus1.d_we = 0;
        bus1.d_be = '0; bus1.d_addr = 32'h80; bus1.d_wdata = '0; bus1.mem_rdata = '0;
        @(negedge clk);
        test_reset();
        test_fetch_only();
        test_store_load();
        test_starvation();
        test_back_to_back();
        test_reset_mid();
        test_limit_one();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
